// File: rtl/adler32_stream_pkg.sv
// adler32_stream_pkg: shared constants and state encoding for the Adler-32 stream engine
package adler32_stream_pkg;
  localparam int unsigned ADLER_MOD_DEFAULT = 65521;
  localparam int unsigned ADLER_INIT_A = 1;
  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;
endpackage

// File: rtl/adler_byte_step.sv
// adler_byte_step: one combinational Adler-32 byte update (A+=byte, B+=A, both mod)
//   a, b         : incoming sums, each < mod
//   data, en     : message byte and its enable; disabled passes sums through
//   mod          : modulus (< 2^16)
//   a_out, b_out : updated sums, each < mod
module adler_byte_step (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [7:0]  data,
  input  logic        en,
  input  logic [15:0] mod,
  output logic [15:0] a_out,
  output logic [15:0] b_out
);
  logic [16:0] a_sum, b_sum, mod17;
  logic [15:0] a_red, b_red;
  // Sums stay below 2*mod, so one conditional subtract reduces them; the
  // difference fits in 16 bits, so only the low half is kept.
  always_comb begin
    mod17 = {1'b0, mod};
    a_sum = {1'b0, a} + {9'b0, data};
    a_red = a_sum >= mod17 ? a_sum[15:0] - mod : a_sum[15:0];
    b_sum = {1'b0, b} + {1'b0, a_red};
    b_red = b_sum >= mod17 ? b_sum[15:0] - mod : b_sum[15:0];
    a_out = en ? a_red : a;
    b_out = en ? b_red : b;
  end
endmodule

// File: rtl/dff_rstval.sv
// dff_rstval: enabled register with asynchronous active-low reset to RSTVAL
//   clock, rst_n : clock and async reset
//   en, d, q     : load enable, next value, registered value
module dff_rstval #(
  parameter int unsigned W = 16,
  parameter logic [W-1:0] RSTVAL = '0
) (
  input  logic         clock,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clock or negedge rst_n)
    if (!rst_n) q <= RSTVAL;
    else if (en) q <= d;
endmodule

// File: rtl/adler32_stream.sv
// adler32_stream: streaming Adler-32 engine, BYTES bytes per beat, seedable, held result
//   clock, rst_n                     : clock, async active-low reset
//   in_valid/in_ready/in_data/in_keep/in_last : message beat handshake (byte 0 first)
//   seed_load, seed                  : load {B,A} continuation value while idle in ACCUM
//   out_valid/out_ready/checksum     : {B,A} result, held until accepted
module adler32_stream
  import adler32_stream_pkg::*;
#(
  parameter int unsigned BYTES = 4,
  parameter int unsigned MOD = ADLER_MOD_DEFAULT,
  parameter int unsigned INIT_A = ADLER_INIT_A
) (
  input  logic               clock,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [8*BYTES-1:0] in_data,
  input  logic [BYTES-1:0]   in_keep,
  input  logic               in_last,
  input  logic               seed_load,
  input  logic [31:0]        seed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        checksum
);
  localparam logic [15:0] M = 16'(MOD);
  localparam logic [15:0] A0 = 16'(INIT_A);
  state_t st, st_n;
  logic [15:0] a_q, b_q, a_d, b_d, seed_a, seed_b;
  logic [BYTES:0][15:0] ca, cb;
  logic xfer, done, seed_ok, en;
  assign ca[0] = a_q;
  assign cb[0] = b_q;
  for (genvar i = 0; i < BYTES; i++) begin : g_step
    adler_byte_step u_step (
      .a(ca[i]),
      .b(cb[i]),
      .data(in_data[8*i +: 8]),
      .en(in_keep[i]),
      .mod(M),
      .a_out(ca[i+1]),
      .b_out(cb[i+1])
    );
  end
  assign in_ready = st == ST_ACCUM;
  assign out_valid = st == ST_HOLD;
  assign checksum = {b_q, a_q};
  assign xfer = in_valid & in_ready;
  assign done = out_valid & out_ready;
  // A beat in the same cycle takes priority over a seed load.
  assign seed_ok = seed_load & in_ready & ~xfer;
  assign en = done | xfer | seed_ok;
  always_comb begin
    seed_a = seed[15:0] >= M ? seed[15:0] - M : seed[15:0];
    seed_b = seed[31:16] >= M ? seed[31:16] - M : seed[31:16];
    a_d = done ? A0 : xfer ? ca[BYTES] : seed_a;
    b_d = done ? 16'h0 : xfer ? cb[BYTES] : seed_b;
    st_n = st == ST_ACCUM ? (xfer & in_last ? ST_HOLD : ST_ACCUM) : (out_ready ? ST_ACCUM : ST_HOLD);
  end
  always_ff @(posedge clock or negedge rst_n)
    if (!rst_n) st <= ST_ACCUM;
    else st <= st_n;
  dff_rstval #(.W(16), .RSTVAL(A0)) u_a (
    .clock(clock), .rst_n(rst_n), .en(en), .d(a_d), .q(a_q)
  );
  dff_rstval #(.W(16), .RSTVAL(16'h0)) u_b (
    .clock(clock), .rst_n(rst_n), .en(en), .d(b_d), .q(b_q)
  );
endmodule

// File: tb/tb_adler32_stream.sv
// tb_adler32_stream: directed, table-driven checks of adler32_stream with BYTES=4
module tb_adler32_stream;
  logic        clock, rst_n, in_valid, in_ready, in_last, seed_load, out_valid, out_ready;
  logic [31:0] in_data, seed, checksum;
  logic [3:0]  in_keep;
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
    logic [31:0] exp;
  } vec_t;
  vec_t vt[6];

  adler32_stream #(.BYTES(4)) dut (
    .clock(clock), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_keep(in_keep), .in_last(in_last),
    .seed_load(seed_load), .seed(seed),
    .out_valid(out_valid), .out_ready(out_ready), .checksum(checksum)
  );

  initial clock = 0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    in_valid = 1; in_data = d; in_keep = k; in_last = l;
    @(posedge clock); #1;
    in_valid = 0; in_last = 0; in_keep = 0;
  endtask

  // Called one cycle after a last beat with out_ready high.
  task automatic finish_msg(input string name, input logic [31:0] exp);
    chk({name, "_valid"}, {31'b0, out_valid}, 32'd1);
    chk({name, "_sum"}, checksum, exp);
    @(posedge clock); #1;
    chk({name, "_valid_drop"}, {31'b0, out_valid}, 32'd0);
    chk({name, "_ready_back"}, {31'b0, in_ready}, 32'd1);
    chk({name, "_reinit"}, checksum, 32'h00000001);
  endtask

  initial begin
    vt[0] = '{32'h696B6957, 4'hF, 1'b0, 32'h03DA0195};
    vt[1] = '{32'h69646570, 4'hF, 1'b0, 32'h0E4E0337};
    vt[2] = '{32'h00000061, 4'h1, 1'b1, 32'h11E60398};
    vt[3] = '{32'hDEADBEEF, 4'h0, 1'b1, 32'h00000001};
    vt[4] = '{32'hFFFFFF61, 4'h1, 1'b1, 32'h00620062};
    vt[5] = '{32'hAAAA6261, 4'h3, 1'b1, 32'h012600C4};
    rst_n = 0; in_valid = 0; in_data = 0; in_keep = 0; in_last = 0;
    seed_load = 0; seed = 0; out_ready = 1;
    #23 rst_n = 1;
    @(posedge clock); #1;
    chk("rst_sum", checksum, 32'h00000001);
    chk("rst_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_valid", {31'b0, out_valid}, 32'd0);

    for (int i = 0; i < 6; i++) begin
      beat(vt[i].data, vt[i].keep, vt[i].last);
      if (vt[i].last) finish_msg($sformatf("vec%0d", i), vt[i].exp);
      else begin
        chk($sformatf("vec%0d_mid_sum", i), checksum, vt[i].exp);
        chk($sformatf("vec%0d_mid_valid", i), {31'b0, out_valid}, 32'd0);
      end
    end

    // 257 bytes of 0xFF: A wraps past 65535
    for (int i = 0; i < 64; i++) beat(32'hFFFFFFFF, 4'hF, 1'b0);
    beat(32'h000000FF, 4'h1, 1'b1);
    finish_msg("ff257", 32'h080F000F);

    // seed so both sums wrap to zero
    seed = 32'h0000FFF0; seed_load = 1;
    @(posedge clock); #1;
    seed_load = 0;
    chk("seed_loaded", checksum, 32'h0000FFF0);
    beat(32'h00000001, 4'h1, 1'b1);
    finish_msg("seed_wrap", 32'h00000000);

    // seed values >= MOD are reduced once
    seed = 32'hFFF5FFF2; seed_load = 1;
    @(posedge clock); #1;
    seed_load = 0;
    chk("seed_reduce", checksum, 32'h00040001);
    beat(32'h00000000, 4'h0, 1'b1);
    finish_msg("seed_reduce_msg", 32'h00040001);

    // seed_load together with a beat: beat wins
    seed = 32'h12345678; seed_load = 1;
    beat(32'h00000061, 4'h1, 1'b1);
    seed_load = 0;
    finish_msg("seed_vs_beat", 32'h00620062);

    // backpressure: result held, new beats and seeds ignored
    out_ready = 0;
    beat(vt[0].data, 4'hF, 1'b0);
    beat(vt[1].data, 4'hF, 1'b0);
    beat(32'h00000061, 4'h1, 1'b1);
    for (int c = 0; c < 5; c++) begin
      in_valid = 1; in_data = 32'h61616161; in_keep = 4'hF; in_last = 1;
      seed = 32'h12345678; seed_load = (c == 2);
      chk($sformatf("hold%0d_ready", c), {31'b0, in_ready}, 32'd0);
      chk($sformatf("hold%0d_valid", c), {31'b0, out_valid}, 32'd1);
      chk($sformatf("hold%0d_sum", c), checksum, 32'h11E60398);
      @(posedge clock); #1;
    end
    in_valid = 0; in_last = 0; in_keep = 0; seed_load = 0;
    chk("hold_end_sum", checksum, 32'h11E60398);
    out_ready = 1;
    @(posedge clock); #1;
    chk("hold_accept_ready", {31'b0, in_ready}, 32'd1);
    chk("hold_accept_valid", {31'b0, out_valid}, 32'd0);
    chk("hold_accept_sum", checksum, 32'h00000001);
    beat(32'h00000061, 4'h1, 1'b1);
    finish_msg("after_hold", 32'h00620062);

    // reset mid-message discards partial sums
    beat(vt[0].data, 4'hF, 1'b0);
    chk("pre_rst_sum", checksum, 32'h03DA0195);
    #2 rst_n = 0;
    #1 chk("async_rst_sum", checksum, 32'h00000001);
    #3 rst_n = 1;
    @(posedge clock); #1;
    beat(vt[0].data, 4'hF, 1'b0);
    beat(vt[1].data, 4'hF, 1'b0);
    beat(32'h00000061, 4'h1, 1'b1);
    finish_msg("after_rst", 32'h11E60398);

    // reset during HOLD discards pending result
    out_ready = 0;
    beat(32'h00000061, 4'h1, 1'b1);
    chk("rst_hold_pre_valid", {31'b0, out_valid}, 32'd1);
    #2 rst_n = 0;
    #1 chk("rst_hold_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_hold_sum", checksum, 32'h00000001);
    #3 rst_n = 1;
    out_ready = 1;
    @(posedge clock); #1;
    chk("rst_hold_ready", {31'b0, in_ready}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
